// File: rtl/fifo_rd_pkg.sv
// ---------------------------------------------------------------------------
// fifo_rd_pkg
// Shared types and constants for the FIFO read-side stream adapter.
//   DEF_DATA_WIDTH : default payload width
//   BUF_DEPTH      : number of output buffer slots
//   buf_idx_t      : slot index (0..BUF_DEPTH-1)
//   buf_cnt_t      : slot occupancy (0..BUF_DEPTH)
//   idx_next()     : ring-pointer increment with wrap at BUF_DEPTH
// ---------------------------------------------------------------------------
package fifo_rd_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int BUF_DEPTH      = 3;

    typedef logic [1:0] buf_idx_t;
    typedef logic [1:0] buf_cnt_t;

    // Depth is not a power of two, so the pointer needs an explicit wrap.
    function automatic buf_idx_t idx_next(input buf_idx_t idx);
        return (idx == buf_idx_t'(BUF_DEPTH - 1)) ? buf_idx_t'(0) : idx + buf_idx_t'(1);
    endfunction

endpackage

// File: rtl/fifo_rd_stream_adapter_if.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream_adapter_if
// Bundles the FIFO read-request side and the output stream side.
//   r_en    : read request to the read pointer logic
//   f_empty : FIFO empty flag (registered, 1 during reset)
//   rdata   : memory read data, valid the cycle after an accepted read
//   m_valid / m_ready / m_data : output stream
//
// Handshake rules: a FIFO read is accepted on an edge where r_en && !f_empty,
// and its data appears on rdata during the following cycle. A stream word is
// transferred on an edge where m_valid && m_ready; while m_valid is high and
// m_ready is low, m_data is held stable and m_valid does not drop.
//
// Modports: master = adapter view, slave = FIFO/consumer view.
// ---------------------------------------------------------------------------
interface fifo_rd_stream_adapter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  r_en;
    logic                  f_empty;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        output r_en, m_valid, m_data,
        input  f_empty, rdata, m_ready
    );

    modport slave (
        input  r_en, m_valid, m_data,
        output f_empty, rdata, m_ready
    );
endinterface

// File: rtl/fifo_rd_slot_buf.sv
// ---------------------------------------------------------------------------
// fifo_rd_slot_buf
// Three-entry ring buffer holding words already read from FIFO memory.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wdata into slot[tail] and advance tail
//   pop      : advance head (caller guarantees count != 0)
//   wdata    : word to store
//   rdata    : slot[head], combinational from registers
//   count    : occupancy 0..3
// ---------------------------------------------------------------------------
module fifo_rd_slot_buf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output buf_cnt_t              count
);

    logic [DATA_WIDTH-1:0] slots [BUF_DEPTH];
    buf_idx_t              head;
    buf_idx_t              tail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= idx_next(tail);
            if (pop)  head <= idx_next(head);
            case ({push, pop})
                2'b10:   count <= count + buf_cnt_t'(1);
                2'b01:   count <= count - buf_cnt_t'(1);
                default: count <= count;
            endcase
        end
    end

    // Slot contents are don't-care after reset, so storage has no reset.
    always_ff @(posedge clk) begin
        if (push) slots[tail] <= wdata;
    end

    assign rdata = slots[head];

    // The read-request throttle keeps count + inflight <= 3, so a full
    // buffer can never see a push.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && count == buf_cnt_t'(BUF_DEPTH)));

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream_adapter
// Read-domain consumer of the asynchronous FIFO. Issues reads, captures the
// one-cycle-latency memory data into a 3-slot buffer and presents it as a
// valid/ready stream at one word per cycle. r_en depends on registers only,
// so there is no combinational path from m_ready to r_en.
//   r_clk, rrst  : read clock, asynchronous active-high reset
//   bus          : FIFO read side and output stream (master modport)
//   rd_count     : words delivered, wraps modulo 2^CNT_WIDTH
//   dbg_count    : buffer occupancy (observation only)
//   dbg_inflight : a read was accepted last cycle and its data is on rdata
// ---------------------------------------------------------------------------
module fifo_rd_stream_adapter
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        r_clk,
    input  logic                        rrst,
    fifo_rd_stream_adapter_if.master    bus,
    output logic [CNT_WIDTH-1:0]        rd_count,
    output buf_cnt_t                    dbg_count,
    output logic                        dbg_inflight
);

    logic                  inflight;
    logic                  accept;
    logic                  pop;
    buf_cnt_t              count;
    logic [2:0]            occupancy;
    logic [DATA_WIDTH-1:0] head_data;

    // Reserve a slot for every word already requested, including the one
    // whose data is still on its way from memory.
    assign occupancy = {1'b0, count} + {2'b00, inflight};
    assign bus.r_en  = !rrst && (occupancy < 3'(BUF_DEPTH));
    assign accept    = bus.r_en && !bus.f_empty;

    assign bus.m_valid = (count != '0);
    assign bus.m_data  = head_data;
    assign pop         = bus.m_valid && bus.m_ready;

    always_ff @(posedge r_clk or posedge rrst) begin
        if (rrst) begin
            inflight <= 1'b0;
            rd_count <= '0;
        end else begin
            inflight <= accept;
            if (pop) rd_count <= rd_count + CNT_WIDTH'(1);
        end
    end

    fifo_rd_slot_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slot_buf (
        .clk   (r_clk),
        .rst   (rrst),
        .push  (inflight),
        .pop   (pop),
        .wdata (bus.rdata),
        .rdata (head_data),
        .count (count)
    );

    assign dbg_count    = count;
    assign dbg_inflight = inflight;

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_stream_adapter
// Directed bench: a queue models the FIFO behind the read pointer logic,
// words leaving the stream are collected and compared with expected lists.
// ---------------------------------------------------------------------------
module tb_fifo_rd_stream_adapter;
    import fifo_rd_pkg::*;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          r_clk = 1'b0;
    logic          rrst;
    logic [CW-1:0] rd_count;
    buf_cnt_t      dbg_count;
    logic          dbg_inflight;

    fifo_rd_stream_adapter_if #(.DATA_WIDTH(DW)) bus ();

    fifo_rd_stream_adapter #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .r_clk        (r_clk),
        .rrst         (rrst),
        .bus          (bus),
        .rd_count     (rd_count),
        .dbg_count    (dbg_count),
        .dbg_inflight (dbg_inflight)
    );

    // ---------------- clock ----------------
    always #5 r_clk = ~r_clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    int            got_step[$];
    int            n_acc;
    int            step_no;

    // ---------------- driver tasks ----------------
    // Called at posedge+1. Applies m_ready for this cycle, notes what the
    // coming edge will accept/deliver, then advances one cycle and updates
    // the FIFO model (rdata carries the accepted word for one cycle).
    task automatic step(input logic rdy);
        logic          acc;
        logic          del;
        logic [DW-1:0] d;
        bus.m_ready = rdy;
        acc = bus.r_en && !bus.f_empty;
        del = bus.m_valid && rdy;
        d   = bus.m_data;
        @(posedge r_clk);
        #1;
        step_no++;
        if (acc) begin
            bus.rdata = fifo_q.pop_front();
            n_acc++;
        end else begin
            bus.rdata = 8'hEE;
        end
        bus.f_empty = (fifo_q.size() == 0);
        if (del) begin
            got_q.push_back(d);
            got_step.push_back(step_no);
        end
    endtask

    task automatic load(input int n, input logic [DW-1:0] base, input logic [DW-1:0] inc);
        logic [DW-1:0] w;
        w = base;
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(w);
            exp_q.push_back(w);
            w = w + inc;
        end
        bus.f_empty = (fifo_q.size() == 0);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        got_step.delete();
        n_acc = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rrst        = 1'b1;
        bus.f_empty = 1'b1;
        bus.m_ready = 1'b0;
        bus.rdata   = 8'hEE;
        step_no     = 0;
        clear_sb();
        #1;
        checks++;
        if (bus.r_en !== 1'b0 || bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: r_en=%b m_valid=%b, required 0 0", bus.r_en, bus.m_valid);
        end
        repeat (3) @(posedge r_clk);
        #1;
        rrst = 1'b0;
        #1;
        checks++;
        if (bus.r_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_r_en: got %b, required 1", bus.r_en);
        end
        checks++;
        if (bus.m_valid !== 1'b0 || rd_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_release_state: m_valid=%b rd_count=%0d, required 0 0", bus.m_valid, rd_count);
        end
        for (int i = 0; i < 4; i++) step(1'b1);
        checks++;
        if (n_acc != 0 || got_q.size() != 0 || bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_empty_idle: accepts=%0d words=%0d m_valid=%b, required 0 0 0",
                     n_acc, got_q.size(), bus.m_valid);
        end
    endtask

    task automatic test_stream();
        int first;
        clear_sb();
        load(4, 8'h11, 8'h11);
        step(1'b1);   // first accept on this edge
        checks++;
        if (bus.m_valid !== 1'b0 || dbg_inflight !== 1'b1) begin
            errors++;
            $display("FAIL stream_after_accept: m_valid=%b inflight=%b, required 0 1", bus.m_valid, dbg_inflight);
        end
        step(1'b1);   // word captured, valid two cycles after accept
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h11) begin
            errors++;
            $display("FAIL stream_latency: m_valid=%b m_data=%h, required 1 11", bus.m_valid, bus.m_data);
        end
        first = step_no + 1;
        for (int i = 0; i < 8; i++) step(1'b1);
        checks++;
        if (got_q.size() != 4) begin
            errors++;
            $display("FAIL stream_count: got %0d words, required 4", got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_step[i] != first + i) begin
                errors++;
                $display("FAIL stream_word%0d: got %h at step %0d, required %h at step %0d",
                         i, got_q[i], got_step[i], exp_q[i], first + i);
            end
        end
        checks++;
        if (rd_count !== 4'd4 || bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: rd_count=%0d m_valid=%b, required 4 0", rd_count, bus.m_valid);
        end
    endtask

    task automatic test_backpressure();
        clear_sb();
        load(8, 8'hA0, 8'h03);
        for (int i = 0; i < 10; i++) step(1'b0);
        checks++;
        if (n_acc != 3) begin
            errors++;
            $display("FAIL bp_accepts: got %0d, required 3", n_acc);
        end
        checks++;
        if (bus.r_en !== 1'b0 || dbg_count !== 2'd3 || dbg_inflight !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: r_en=%b count=%0d inflight=%b, required 0 3 0",
                     bus.r_en, dbg_count, dbg_inflight);
        end
        for (int i = 0; i < 40 && got_q.size() < 8; i++) step(1'b1);
        checks++;
        if (got_q.size() != 8) begin
            errors++;
            $display("FAIL bp_drain_count: got %0d words, required 8", got_q.size());
        end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || (i > 0 && got_step[i] != got_step[0] + i)) begin
                errors++;
                $display("FAIL bp_word%0d: got %h at step %0d, required %h at step %0d",
                         i, got_q[i], got_step[i], exp_q[i], got_step[0] + i);
            end
        end
        checks++;
        if (rd_count !== 4'd12) begin
            errors++;
            $display("FAIL bp_rd_count: got %0d, required 12", rd_count);
        end
    endtask

    task automatic test_alternate();
        logic          hv;
        logic [DW-1:0] hold;
        logic          rdy;
        clear_sb();
        load(6, 8'h5A, 8'h11);
        for (int i = 0; i < 40 && got_q.size() < 6; i++) begin
            rdy  = (i % 2 == 0);
            hv   = bus.m_valid && !rdy;
            hold = bus.m_data;
            step(rdy);
            if (hv) begin
                checks++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== hold) begin
                    errors++;
                    $display("FAIL alt_hold: m_valid=%b m_data=%h, required 1 %h", bus.m_valid, bus.m_data, hold);
                end
            end
            checks++;
            if (int'(dbg_count) + int'(dbg_inflight) > 3) begin
                errors++;
                $display("FAIL alt_occupancy: count=%0d inflight=%b, required sum <= 3", dbg_count, dbg_inflight);
            end
        end
        checks++;
        if (got_q.size() != 6) begin
            errors++;
            $display("FAIL alt_count: got %0d words, required 6", got_q.size());
        end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL alt_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (rd_count !== 4'd2) begin   // 18 deliveries modulo 16
            errors++;
            $display("FAIL alt_rd_count: got %0d, required 2", rd_count);
        end
    endtask

    task automatic test_reset_mid();
        logic reached;
        clear_sb();
        load(8, 8'hC0, 8'h01);
        reached = 1'b0;
        for (int i = 0; i < 10 && !reached; i++) begin
            step(1'b0);
            reached = (dbg_count == 2'd2) && dbg_inflight;
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL rstmid_setup: count=%0d inflight=%b, required 2 1", dbg_count, dbg_inflight);
        end
        #2;
        rrst = 1'b1;
        #1;
        checks++;
        if (bus.m_valid !== 1'b0 || bus.r_en !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: m_valid=%b r_en=%b, required 0 0", bus.m_valid, bus.r_en);
        end
        fifo_q.delete();
        bus.f_empty = 1'b1;
        bus.rdata   = 8'hEE;
        repeat (2) @(posedge r_clk);
        #1;
        rrst = 1'b0;
        step(1'b1);
        checks++;
        if (dbg_count !== 2'd0 || rd_count !== 4'd0 || bus.m_valid !== 1'b0 || dbg_inflight !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after: count=%0d rd_count=%0d m_valid=%b inflight=%b, required 0 0 0 0",
                     dbg_count, rd_count, bus.m_valid, dbg_inflight);
        end
    endtask

    task automatic test_wrap();
        clear_sb();
        load(17, 8'h01, 8'h07);
        for (int i = 0; i < 80 && got_q.size() < 17; i++) step(1'b1);
        checks++;
        if (got_q.size() != 17) begin
            errors++;
            $display("FAIL wrap_count: got %0d words, required 17", got_q.size());
        end
        for (int i = 0; i < 17 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL wrap_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (rd_count !== 4'd1) begin
            errors++;
            $display("FAIL wrap_rd_count: got %0d, required 1", rd_count);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_alternate();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
